bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
//
// PURPOSE
// - Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// - Consumes the 9-bit result {Cout,S[7:0]} of the 8-bit ripple adder stage.
// - Produces packed BCD digits for the FLOAT_TO_DECIMAL output path.
// - Iterative, to keep area small; start/busy/done handshake to the sequencer.
//
// PARAMETERS
// - BIN_W   default 9  binary input width ({Cout,S} of the 8-bit adder)
// - DIGITS  default 3  number of BCD output digits (10^DIGITS > 2^BIN_W-1 for no overflow)
//
// PORTS
// - clk       in   1          rising-edge clock
// - rst_n     in   1          asynchronous active-low reset
// - start     in   1          request conversion of bin_in; sampled only in IDLE
// - bin_in    in   BIN_W      unsigned binary value, captured on accepted start
// - busy      out  1          high while a conversion is in progress
// - done      out  1          one-cycle pulse, bcd_out/ovf valid from this cycle
// - bcd_out   out  4*DIGITS   packed BCD, digit 0 in [3:0]
// - ovf       out  1          bin_in >= 10^DIGITS; bcd_out holds low DIGITS digits
//
// BEHAVIOUR
// - Reset: busy=0, done=0, bcd_out=0, ovf=0; FSM->IDLE; shift reg and counter cleared.
//   Asynchronous assertion aborts any conversion; done never pulses for an aborted job.
// - FSM states: IDLE, SHIFT, FIN.
//   - IDLE: start=1 -> capture bin_in; clear scratch; cnt=BIN_W; busy=1; go SHIFT.
//   - SHIFT: per cycle, each scratch digit >=5 gets +3, then {scratch,bin} <<= 1.
//     cnt decrements; cnt reaching 0 -> FIN.
//   - FIN: bcd_out <= scratch; ovf <= overflow flag; done=1 for this cycle only;
//     busy=0; go IDLE.
// - Latency: start accepted at edge N -> done high in cycle N+BIN_W+1 (10 for defaults).
//   Back-to-back: start may be reasserted in the cycle after done.
// - start while busy or in FIN: ignored, not queued; bin_in changes then have no effect.
// - Scratch register: 4*DIGITS+4 bits wide, so a carry out of the top digit is caught.
//   Any nonzero bit above 4*DIGITS sets the overflow flag.
// - The add-3 correction is per digit on 4-bit nibbles; no carry propagates between digits.
// - bcd_out and ovf hold their last value until the next FIN; they are not cleared by start.
// - bin_in=0 converts normally (BIN_W cycles) to all-zero BCD, ovf=0.
//
// CONFIGURATION
// - BCD_SIGN_EN defined:
//   - Adds port sign_in (in, 1), captured with bin_in on an accepted start.
//   - Adds port sign_out (out, 1), updated in FIN together with bcd_out; reset 0.
//   - Carries the IEEE754 sign bit alongside the magnitude; the magnitude path is unchanged.
// - BCD_SIGN_EN undefined: neither port exists; the block is magnitude only.
//
// TESTING
// - bin_in=9'h101 (128+129, Cout=1), start 1 cycle -> done at +10 cycles, bcd_out=12'h257, ovf=0.
// - bin_in=9'd113 (106+7) -> bcd_out=12'h113; 9'd48 (47+1) -> 12'h048.
// - bin_in=0 -> 12'h000; bin_in=9'h1FF -> 12'h511, ovf=0.
// - DIGITS=2, bin_in=9'd255 -> bcd_out=8'h55, ovf=1.
// - start pulsed at cycle 3 of a busy conversion with a different bin_in -> ignored;
//   a single done pulse with the first result.
// - rst_n low at cycle 5 of a conversion -> outputs 0 immediately, no done; next start
//   converts correctly. With BCD_SIGN_EN, sign_in=1, bin_in=9'd20 -> sign_out=1, bcd_out=12'h020.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock).
// Optional sign pass-through (sign_in/sign_out) is enabled by defining BCD_SIGN_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 9,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
`ifdef BCD_SIGN_EN
  input  logic                  sign_in,
  output logic                  sign_out,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  // One spare nibble above the output digits catches carries for overflow detection.
  localparam int SW    = 4*DIGITS + 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] FIN   = 2'd2;

  logic [1:0]       state;
  logic [SW-1:0]    scratch;
  logic [SW-1:0]    adj;
  logic [BIN_W-1:0] bin_sr;
  logic [CNT_W-1:0] cnt;
  logic             ovf_sticky;
`ifdef BCD_SIGN_EN
  logic             sign_q;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS + 1; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      scratch    <= '0;
      bin_sr     <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      done       <= 1'b0;
      bcd_out    <= '0;
      ovf        <= 1'b0;
`ifdef BCD_SIGN_EN
      sign_q     <= 1'b0;
      sign_out   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr     <= bin_in;
            scratch    <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= CNT_W'(BIN_W);
`ifdef BCD_SIGN_EN
            sign_q     <= sign_in;
`endif
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          {scratch, bin_sr} <= {adj[SW-2:0], bin_sr, 1'b0};
          // A bit leaving the spare nibble would be lost; remember it.
          ovf_sticky        <= ovf_sticky | adj[SW-1];
          cnt               <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= FIN;
        end
        FIN: begin
          bcd_out  <= scratch[4*DIGITS-1:0];
          ovf      <= ovf_sticky | (|scratch[SW-1:4*DIGITS]);
          done     <= 1'b1;
`ifdef BCD_SIGN_EN
          sign_out <= sign_q;
`endif
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance share stimulus;
// directed vectors push expected results, monitors pop on each done pulse.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  bin_in = '0;
  logic        sign_in = 1'b0;
  logic        busy3, done3, ovf3, busy2, done2, ovf2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;
`ifdef BCD_SIGN_EN
  logic        sign3, sign2;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    logic        sgn;
    int          cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];

  bin_to_bcd_seq #(.BIN_W(9), .DIGITS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
`ifdef BCD_SIGN_EN
    .sign_in(sign_in), .sign_out(sign3),
`endif
    .busy(busy3), .done(done3), .bcd_out(bcd3), .ovf(ovf3)
  );

  bin_to_bcd_seq #(.BIN_W(9), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
`ifdef BCD_SIGN_EN
    .sign_in(sign_in), .sign_out(sign2),
`endif
    .busy(busy2), .done(done2), .bcd_out(bcd2), .ovf(ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin : mon3
    exp_t e;
    if (rst_n && done3) begin
      if (q3.size() == 0) begin
        check("unexpected_done3", 32'd1, 32'd0);
      end else begin
        e = q3.pop_front();
        check("bcd3", 32'(bcd3), 32'(e.bcd));
        check("ovf3", 32'(ovf3), 32'(e.ovf));
        check("latency3", 32'(cyc), 32'(e.cyc + 11));
`ifdef BCD_SIGN_EN
        check("sign3", 32'(sign3), 32'(e.sgn));
`endif
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        check("unexpected_done2", 32'd1, 32'd0);
      end else begin
        e = q2.pop_front();
        check("bcd2", 32'(bcd2), 32'(e.bcd));
        check("ovf2", 32'(ovf2), 32'(e.ovf));
`ifdef BCD_SIGN_EN
        check("sign2", 32'(sign2), 32'(e.sgn));
`endif
      end
    end
  end

  // Drive one start pulse; optionally record the expected results for both instances.
  task automatic issue(input logic [8:0] b, input logic sgn, input bit expect_done,
                       input logic [11:0] e3, input logic o3,
                       input logic [7:0] e2, input logic o2);
    @(posedge clk); #1;
    bin_in  = b;
    sign_in = sgn;
    start   = 1'b1;
    if (expect_done) begin
      q3.push_back('{bcd: e3, ovf: o3, sgn: sgn, cyc: cyc});
      q2.push_back('{bcd: {4'h0, e2}, ovf: o2, sgn: sgn, cyc: cyc});
    end
    @(posedge clk); #1;
    start   = 1'b0;
    bin_in  = ~b;
    sign_in = ~sgn;
  endtask

  // Wait (bounded) until both monitors have consumed every expected result.
  task automatic drain(input string name);
    int n = 0;
    while ((q3.size() != 0 || q2.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (q3.size() != 0 || q2.size() != 0) begin
      check({"done_timeout_", name}, 32'(q3.size() + q2.size()), 32'd0);
      q3.delete();
      q2.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [8:0] b, input logic sgn,
                     input logic [11:0] e3, input logic o3,
                     input logic [7:0] e2, input logic o2, input string name);
    issue(b, sgn, 1'b1, e3, o3, e2, o2);
    drain(name);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #12;
    check("rst_busy", 32'({busy3, busy2}), 32'd0);
    check("rst_done", 32'({done3, done2}), 32'd0);
    check("rst_bcd",  32'({bcd3, bcd2}), 32'd0);
    check("rst_ovf",  32'({ovf3, ovf2}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run(9'h101, 1'b0, 12'h257, 1'b0, 8'h57, 1'b1, "v257");
    run(9'd113, 1'b0, 12'h113, 1'b0, 8'h13, 1'b1, "v113");
    run(9'd48,  1'b0, 12'h048, 1'b0, 8'h48, 1'b0, "v048");
    run(9'd0,   1'b0, 12'h000, 1'b0, 8'h00, 1'b0, "v000");
    run(9'd255, 1'b0, 12'h255, 1'b0, 8'h55, 1'b1, "v255");
    run(9'd99,  1'b0, 12'h099, 1'b0, 8'h99, 1'b0, "v099");
    run(9'd100, 1'b0, 12'h100, 1'b0, 8'h00, 1'b1, "v100");

    // Back-to-back: second start raised in the cycle right after done.
    issue(9'd20, 1'b0, 1'b1, 12'h020, 1'b0, 8'h20, 1'b0);
    begin
      int n = 0;
      while (!done3 && n < 30) begin @(negedge clk); n++; end
      check("b2b_first_done", 32'(done3), 32'd1);
    end
    issue(9'd98, 1'b0, 1'b1, 12'h098, 1'b0, 8'h98, 1'b0);
    drain("b2b");

    // Start during a busy conversion is ignored.
    issue(9'd113, 1'b0, 1'b1, 12'h113, 1'b0, 8'h13, 1'b1);
    @(posedge clk); #1;
    check("busy_mid", 32'({busy3, busy2}), 32'h3);
    bin_in = 9'd48;
    start  = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    drain("ignored_start");
    repeat (15) @(negedge clk);

    run(9'h1FF, 1'b0, 12'h511, 1'b0, 8'h11, 1'b1, "v511");

    // Abort: reset mid-conversion clears outputs immediately and never pulses done.
    issue(9'd300, 1'b0, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'({busy3, busy2}), 32'd0);
    check("abort_done", 32'({done3, done2}), 32'd0);
    check("abort_bcd",  32'({bcd3, bcd2}), 32'd0);
    check("abort_ovf",  32'({ovf3, ovf2}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    run(9'd113, 1'b0, 12'h113, 1'b0, 8'h13, 1'b1, "after_abort");

`ifdef BCD_SIGN_EN
    run(9'd20, 1'b1, 12'h020, 1'b0, 8'h20, 1'b0, "sign_neg");
    run(9'd48, 1'b0, 12'h048, 1'b0, 8'h48, 1'b0, "sign_pos");
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
